// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage data-memory responder with fixed access latency
// Optional feature macro: DMEM_STATS_EN (adds stat_loads/stat_stores/stat_errs counters)
// Ports:
//   clk, reset_n                  rising-edge clock, synchronous active-low reset
//   req_valid, req_ready          request handshake from the MEM stage
//   req_we, req_byte, req_sign    store/load, byte/word, sign-extend byte loads
//   req_addr, req_wdata           byte address, store data (byte stores use [7:0])
//   rsp_valid, rsp_rdata, rsp_err one-cycle response strobe, load data, error flag
//   stall                         high while an accepted access has not yet responded
//   stat_loads/stores/errs        saturating response counters (DMEM_STATS_EN only)
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic        req_sign,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0] stat_loads,
  output logic [15:0] stat_stores,
  output logic [15:0] stat_errs
`endif
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // WAIT spends LATENCY-1 cycles, counting WAIT_INIT down to 0.
  localparam logic [3:0]  WAIT_INIT   = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  localparam logic [15:0] DEPTH_LIMIT = 16'(DEPTH_WORDS);

  logic [1:0]    state;
  logic [3:0]    count;
  logic          r_we;
  logic          r_byte;
  logic          r_sign;
  logic [15:0]   r_addr;
  logic [15:0]   r_wdata;
  logic [15:0]   mem [DEPTH_WORDS];

  logic          in_resp;
  logic          accept;
  logic          misaligned;
  logic          out_of_range;
  logic          acc_err;
  logic [AW-1:0] widx;
  logic [15:0]   rword;
  logic [7:0]    rbyte;
  logic [15:0]   load_data;

  // Outputs are gated by reset_n so they read 0 for the whole reset cycle,
  // regardless of the state held before reset was asserted.
  assign in_resp   = reset_n && (state == S_RESP);
  assign req_ready = reset_n && ((state == S_IDLE) || (state == S_RESP));
  assign accept    = req_valid && req_ready;
  assign stall     = reset_n && ((state == S_WAIT) ||
                                 ((state == S_IDLE) && req_valid && (LATENCY > 1)));

  assign misaligned   = !r_byte && r_addr[0];
  assign out_of_range = {1'b0, r_addr[15:1]} >= DEPTH_LIMIT;
  assign acc_err      = misaligned || out_of_range;
  assign widx         = r_addr[AW:1];

  // Read happens in the RESP cycle so a store finished earlier is visible.
  assign rword = mem[widx];
  assign rbyte = r_addr[0] ? rword[15:8] : rword[7:0];

  always_comb begin
    load_data = rword;
    if (r_byte) begin
      load_data = {{8{r_sign & rbyte[7]}}, rbyte};
    end
  end

  assign rsp_valid = in_resp;
  assign rsp_err   = in_resp && acc_err;
  assign rsp_rdata = (in_resp && !acc_err && !r_we) ? load_data : 16'h0000;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      count   <= 4'd0;
      r_we    <= 1'b0;
      r_byte  <= 1'b0;
      r_sign  <= 1'b0;
      r_addr  <= 16'h0000;
      r_wdata <= 16'h0000;
    end else begin
      if (accept) begin
        r_we    <= req_we;
        r_byte  <= req_byte;
        r_sign  <= req_sign;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      case (state)
        S_IDLE, S_RESP: begin
          if (accept) begin
            state <= (LATENCY == 1) ? S_RESP : S_WAIT;
            count <= WAIT_INIT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (count == 4'd0) begin
            state <= S_RESP;
          end else begin
            count <= count - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Store commits on the edge that ends RESP; in_resp already excludes reset.
  always_ff @(posedge clk) begin
    if (in_resp && r_we && !acc_err) begin
      if (!r_byte) begin
        mem[widx] <= r_wdata;
      end else if (r_addr[0]) begin
        mem[widx][15:8] <= r_wdata[7:0];
      end else begin
        mem[widx][7:0] <= r_wdata[7:0];
      end
    end
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_loads  <= 16'h0000;
      stat_stores <= 16'h0000;
      stat_errs   <= 16'h0000;
    end else if (in_resp) begin
      if (acc_err) begin
        if (stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
      end else if (r_we) begin
        if (stat_stores != 16'hFFFF) stat_stores <= stat_stores + 16'd1;
      end else begin
        if (stat_loads != 16'hFFFF) stat_loads <= stat_loads + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder (LATENCY=2 and LATENCY=3 instances)
module tb_dmem_responder;

  logic        clk;
  logic        reset_n;

  logic        a_valid, a_ready, a_we, a_byte, a_sign;
  logic [15:0] a_addr, a_wdata;
  logic        a_rsp_valid, a_rsp_err, a_stall;
  logic [15:0] a_rsp_rdata;

  logic        b_valid, b_ready, b_we, b_byte, b_sign;
  logic [15:0] b_addr, b_wdata;
  logic        b_rsp_valid, b_rsp_err, b_stall;
  logic [15:0] b_rsp_rdata;

`ifdef DMEM_STATS_EN
  logic [15:0] a_stat_loads, a_stat_stores, a_stat_errs;
  logic [15:0] b_stat_loads, b_stat_stores, b_stat_errs;
`endif

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we), .req_byte(a_byte),
    .req_sign(a_sign), .req_addr(a_addr), .req_wdata(a_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err), .stall(a_stall)
`ifdef DMEM_STATS_EN
    , .stat_loads(a_stat_loads), .stat_stores(a_stat_stores), .stat_errs(a_stat_errs)
`endif
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we), .req_byte(b_byte),
    .req_sign(b_sign), .req_addr(b_addr), .req_wdata(b_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .stall(b_stall)
`ifdef DMEM_STATS_EN
    , .stat_loads(b_stat_loads), .stat_stores(b_stat_stores), .stat_errs(b_stat_errs)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] ref_mem [256];
  int n_loads  = 0;
  int n_stores = 0;
  int n_errs   = 0;

  logic [15:0] s_addr [4];
  logic [15:0] s_wd   [4];
  logic [15:0] s_exp  [4];
  logic        s_we   [4];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed little-endian memory of 256 words, plain arithmetic.
  task automatic model(input logic we, input logic byt, input logic sgn,
                       input logic [15:0] addr, input logic [15:0] wdata,
                       output logic [15:0] rd, output logic err);
    int idx;
    int w;
    int b;
    idx = int'(addr) / 2;
    err = (!byt && (int'(addr) % 2 == 1)) || (idx >= 256);
    rd  = 16'h0000;
    if (err) begin
      n_errs++;
    end else if (we) begin
      n_stores++;
      w = int'(ref_mem[idx]);
      if (!byt)                    w = int'(wdata);
      else if (int'(addr) % 2 == 1) w = (w % 256) + (int'(wdata) % 256) * 256;
      else                         w = (w - w % 256) + int'(wdata) % 256;
      ref_mem[idx] = 16'(w);
    end else begin
      n_loads++;
      w = int'(ref_mem[idx]);
      if (!byt) begin
        rd = 16'(w);
      end else begin
        b  = (int'(addr) % 2 == 1) ? w / 256 : w % 256;
        rd = (sgn && b >= 128) ? 16'(b + 65280) : 16'(b);
      end
    end
  endtask

  // One access on the LATENCY=2 instance; entered and left just after a rising edge in IDLE.
  task automatic access(input logic we, input logic byt, input logic sgn,
                        input logic [15:0] addr, input logic [15:0] wdata,
                        output logic [15:0] rd, output logic err);
    logic [15:0] erd;
    logic        eerr;
    a_valid = 1'b1; a_we = we; a_byte = byt; a_sign = sgn; a_addr = addr; a_wdata = wdata;
    #1;
    chk1("ready_idle", a_ready, 1'b1);
    chk1("stall_on_req", a_stall, 1'b1);
    @(posedge clk); #1;
    model(we, byt, sgn, addr, wdata, erd, eerr);
    a_valid = 1'b0;
    a_we = 1'($urandom); a_byte = 1'($urandom); a_sign = 1'($urandom);
    a_addr = 16'($urandom); a_wdata = 16'($urandom);
    chk1("wait_no_rsp", a_rsp_valid, 1'b0);
    chk1("wait_stall", a_stall, 1'b1);
    chk1("wait_ready", a_ready, 1'b0);
    @(posedge clk); #1;
    chk1("rsp_valid", a_rsp_valid, 1'b1);
    chk1("rsp_stall", a_stall, 1'b0);
    chk1("rsp_ready", a_ready, 1'b1);
    chk("rsp_rdata", a_rsp_rdata, erd);
    chk1("rsp_err", a_rsp_err, eerr);
    rd  = a_rsp_rdata;
    err = a_rsp_err;
    @(posedge clk); #1;
    chk1("rsp_one_cycle", a_rsp_valid, 1'b0);
  endtask

  initial begin
    logic [15:0] rd;
    logic        err;
    logic [15:0] addr;
    logic [15:0] prior;
    int          sel;

    reset_n = 1'b0;
    a_valid = 1'b0; a_we = 1'b0; a_byte = 1'b0; a_sign = 1'b0; a_addr = 16'h0; a_wdata = 16'h0;
    b_valid = 1'b0; b_we = 1'b0; b_byte = 1'b0; b_sign = 1'b0; b_addr = 16'h0; b_wdata = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk1("reset_rsp_valid", a_rsp_valid, 1'b0);
    chk("reset_rdata", a_rsp_rdata, 16'h0000);
    chk1("reset_err", a_rsp_err, 1'b0);
    chk1("reset_stall", a_stall, 1'b0);
    chk1("reset_ready", a_ready, 1'b0);
    chk1("reset_ready_b", b_ready, 1'b0);
    reset_n = 1'b1;
    #1;
    chk1("post_reset_ready", a_ready, 1'b1);
    chk1("idle_stall", a_stall, 1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < 32; i++) access(1'b1, 1'b0, 1'b0, 16'(i * 2), 16'($urandom), rd, err);

    access(1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, rd, err);
    chk1("store_beef_err", err, 1'b0);
    access(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, rd, err);
    chk("load_beef", rd, 16'hBEEF);

    access(1'b1, 1'b0, 1'b0, 16'h0010, 16'h1234, rd, err);
    access(1'b1, 1'b1, 1'b0, 16'h0011, 16'h0080, rd, err);
    access(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, rd, err);
    chk("merge_word", rd, 16'h8034);
    access(1'b0, 1'b1, 1'b1, 16'h0011, 16'h0000, rd, err);
    chk("byte_signed", rd, 16'hFF80);
    access(1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000, rd, err);
    chk("byte_unsigned", rd, 16'h0080);

    access(1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000, rd, err);
    chk1("misaligned_err", err, 1'b1);
    chk("misaligned_rdata", rd, 16'h0000);
    prior = ref_mem[0];
    access(1'b1, 1'b0, 1'b0, 16'h0200, 16'h0000 ^ ~prior, rd, err);
    chk1("oor_err", err, 1'b1);
    access(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, rd, err);
    chk("oor_word0_kept", rd, prior);

    for (int i = 0; i < 80; i++) begin
      sel = int'($urandom_range(0, 7));
      if (sel == 0)      addr = 16'h0200 + 16'($urandom_range(0, 255));
      else if (sel == 1) addr = 16'hFF00 | 16'($urandom_range(0, 255));
      else               addr = 16'($urandom_range(0, 63));
      access(1'($urandom), 1'($urandom), 1'($urandom), addr, 16'($urandom), rd, err);
    end

    // Reset while a store is waiting: nothing written, no response.
    access(1'b1, 1'b0, 1'b0, 16'h0020, 16'hA0A0, rd, err);
    a_valid = 1'b1; a_we = 1'b1; a_byte = 1'b0; a_sign = 1'b0; a_addr = 16'h0020; a_wdata = 16'h5555;
    @(posedge clk); #1;
    a_valid = 1'b0;
    chk1("abort_in_wait", a_stall, 1'b1);
    reset_n = 1'b0;
    #1;
    chk1("abort_rst_rsp", a_rsp_valid, 1'b0);
    chk1("abort_rst_stall", a_stall, 1'b0);
    chk1("abort_rst_ready", a_ready, 1'b0);
    chk("abort_rst_rdata", a_rsp_rdata, 16'h0000);
    chk1("abort_rst_err", a_rsp_err, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    n_loads = 0; n_stores = 0; n_errs = 0;
    for (int i = 0; i < 3; i++) begin
      chk1("abort_no_rsp", a_rsp_valid, 1'b0);
      @(posedge clk); #1;
    end
    access(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, rd, err);
    chk("abort_kept", rd, 16'hA0A0);

    // LATENCY=3 instance, request held valid across four back-to-back accesses.
    s_we[0] = 1'b1; s_addr[0] = 16'h0040; s_wd[0] = 16'($urandom);
    s_we[1] = 1'b1; s_addr[1] = 16'h0042; s_wd[1] = 16'($urandom);
    s_we[2] = 1'b0; s_addr[2] = 16'h0040; s_wd[2] = 16'h0000;
    s_we[3] = 1'b0; s_addr[3] = 16'h0042; s_wd[3] = 16'h0000;
    s_exp[0] = 16'h0000; s_exp[1] = 16'h0000; s_exp[2] = s_wd[0]; s_exp[3] = s_wd[1];
    b_valid = 1'b1; b_we = s_we[0]; b_addr = s_addr[0]; b_wdata = s_wd[0];
    #1;
    chk1("b_ready_idle", b_ready, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k < 3) begin
        b_we = s_we[k + 1]; b_addr = s_addr[k + 1]; b_wdata = s_wd[k + 1];
      end else begin
        b_valid = 1'b0;
      end
      for (int c = 0; c < 2; c++) begin
        chk1("b_gap_rsp", b_rsp_valid, 1'b0);
        chk1("b_gap_ready", b_ready, 1'b0);
        @(posedge clk); #1;
      end
      chk1("b_rsp_valid", b_rsp_valid, 1'b1);
      chk("b_rsp_rdata", b_rsp_rdata, s_exp[k]);
      chk1("b_rsp_err", b_rsp_err, 1'b0);
      chk1("b_resp_ready", b_ready, 1'b1);
    end
    @(posedge clk); #1;
    chk1("b_tail_idle", b_rsp_valid, 1'b0);

`ifdef DMEM_STATS_EN
    access(1'b0, 1'b0, 1'b0, 16'h0005, 16'h0000, rd, err);
    chk("stat_loads", a_stat_loads, 16'(n_loads));
    chk("stat_stores", a_stat_stores, 16'(n_stores));
    chk("stat_errs", a_stat_errs, 16'(n_errs));
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("stat_loads_clr", a_stat_loads, 16'h0000);
    chk("stat_stores_clr", a_stat_stores, 16'h0000);
    chk("stat_errs_clr", a_stat_errs, 16'h0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
